rip_nr1w_bram: RTL
==================

# rip_nr1w_bram

Parametrised N-read / 1-write block-RAM memory for the rip-cpu datapath, for register files and multi-consumer tables. Extends the 2-read/1-write primitive in four ways: a configurable number of read ports, per-byte write strobes, a selectable read-during-write mode with same-cycle forwarding, and a post-reset clear sequencer. Each read port is built from its own replicated BRAM copy, and every copy receives every write.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10: address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2: number of read ports, ≥ 1.
- WRITE_FIRST, 0: 0 = read-first (a same-cycle read returns the old word); 1 = write-first (returns the byte-merged new word).
- CLEAR_ON_RESET, 1: 1 = after reset, write CLEAR_VALUE to every address before accepting accesses.
- CLEAR_VALUE, 0: DATA_WIDTH-bit fill value used by the clear sequencer.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- we  in  1  write request.
- wstrb  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- re  in  NUM_READ  per-port read enable.
- raddr  in  NUM_READ*ADDR_WIDTH  port k address in slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_READ*DATA_WIDTH  port k data in slice [k*DATA_WIDTH +: DATA_WIDTH], registered.
- init_done  out  1  high once the memory accepts accesses.

## Operation
- Two-state FSM:
  - CLEAR: entered on reset.
  - READY: entered when the clear finishes, or entered immediately when CLEAR_ON_RESET=0.
  - READY is left only by reset.
- CLEAR state:
  - An ADDR_WIDTH+1-bit counter starts at 0 and writes CLEAR_VALUE to address counter[ADDR_WIDTH-1:0] in every copy, all bytes, once per cycle.
  - When the write to address 2**ADDR_WIDTH-1 takes place, the FSM moves to READY.
  - we, re, wstrb, waddr, wdata and raddr are ignored; rdata holds 0.
- READY state, write:
  - When we=1, for each i with wstrb[i]=1, byte i of ram[waddr] is written in all NUM_READ copies.
  - we=1 with wstrb=0 is a no-op.
- READY state, read: when re[k]=1, rdata[k] is loaded with ram[raddr[k]]. When re[k]=0, rdata[k] holds its value.
- Read-during-write, when re[k]=1, we=1 and raddr[k]==waddr:
  - WRITE_FIRST=0: rdata[k] gets the pre-write word.
  - WRITE_FIRST=1: rdata[k] gets the merged word: wdata bytes where wstrb=1, old bytes elsewhere.
- Reads on different ports are fully independent; any combination of ports may read the same address.
- The RAM array itself is not reset. Without a clear, contents after power-up are undefined.

## Timing
- Reset values while rstn=0: rdata = 0 on all ports; init_done = 0; FSM in CLEAR; clear counter = 0.
- Clear with CLEAR_ON_RESET=1:
  - Rising edge n after rstn deasserts (n = 1..2**ADDR_WIDTH) writes address n-1.
  - init_done rises on edge 2**ADDR_WIDTH.
  - The first access is sampled on edge 2**ADDR_WIDTH+1.
- Clear with CLEAR_ON_RESET=0: init_done rises on the first edge after rstn deasserts; accesses are accepted from the next edge.
- Read latency: 1 cycle. Address and re[k] are sampled at edge t; rdata[k] is valid after edge t and stays stable until the next enabled read.
- A write at edge t is visible to a different-cycle read sampled at edge t+1 or later.
- Reset asserted mid-clear or mid-operation: outputs go to their reset values immediately (asynchronous). After release, the clear restarts from address 0. An in-flight write on the reset edge is not guaranteed.
- Counter wrap: terminal detection is on address 2**ADDR_WIDTH-1, with no extra cycle. The counter never re-enters the clear loop without a reset.

## Test plan
- Clear, CLEAR_ON_RESET=1, ADDR_WIDTH=4, CLEAR_VALUE=32'hDEADBEEF:
  - Release rstn and count edges → init_done=1 exactly at edge 16.
  - Reads of addresses 0..15 on both ports → all return 32'hDEADBEEF.
  - A write issued at edge 5 → no effect.
- Byte strobes:
  - Write 32'h11223344 to address 3 with wstrb=4'hF.
  - Then write 32'hAABBCCDD to address 3 with wstrb=4'b0101.
  - Read port 0, address 3 → 32'h11BB33DD one cycle later.
- Read-during-write: with address 7 = 32'h0, issue the same-cycle write 32'hCAFEF00D (wstrb=4'hF) and a port 1 read of address 7.
  - WRITE_FIRST=0 → rdata[1]=32'h0.
  - WRITE_FIRST=1 → rdata[1]=32'hCAFEF00D.
  - The next read of address 7 returns 32'hCAFEF00D in both modes.
- Multiport, NUM_READ=4:
  - After writing address k with 32'h100+k, read addresses 3, 0, 3, 9 in one cycle → 32'h103, 32'h100, 32'h103, 32'h109.
  - Drop re[2] and change raddr[2] → rdata[2] holds 32'h103.
- Reset mid-clear: assert rstn=0 at clear edge 6.
  - → rdata=0 and init_done=0 immediately.
  - After release, init_done rises exactly 2**ADDR_WIDTH edges later.
  - All addresses read back as CLEAR_VALUE.
- Random regression: random we/wstrb/re/addresses against a byte-level reference model in both WRITE_FIRST modes; 10k cycles, zero mismatches.

Source files
------------

// File: rtl/rip_nr1w_bram.sv
`default_nettype none
// ============================================================================
// Module   : rip_nr1w_bram
// Brief    : N-read / 1-write replicated block RAM with byte strobes,
//            selectable read-during-write mode and a post-reset clear.
// Revision : 1.0 - initial release
// ============================================================================
module rip_nr1w_bram #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    NUM_READ       = 2,
  parameter int                    WRITE_FIRST    = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           we,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [NUM_READ-1:0]            re,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  output logic                           init_done
);

  localparam int                  c_NUM_BYTES = DATA_WIDTH / 8;
  localparam int                  c_DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_CLR_LAST  = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH:0]     r_clr_cnt;
  logic                    w_ready;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_data;
  logic [c_NUM_BYTES-1:0]  w_mem_strb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The clear sequencer borrows the shared write port while in CLEAR.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = waddr;
    w_mem_data  = wdata;
    w_mem_strb  = wstrb;
    case (r_state)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          w_mem_we   = 1'b1;
          w_mem_addr = r_clr_cnt[ADDR_WIDTH-1:0];
          w_mem_data = CLEAR_VALUE;
          w_mem_strb = '1;
          if (r_clr_cnt == c_CLR_LAST) begin
            w_state_nxt = ST_READY;
          end
        end else begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_ready  = 1'b1;
        w_mem_we = we;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR && CLEAR_ON_RESET != 0) begin
      r_clr_cnt <= r_clr_cnt + (ADDR_WIDTH+1)'(1);
    end
  end

  assign init_done = (r_state == ST_READY);

  for (genvar k = 0; k < NUM_READ; k++) begin : g_copy
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_fwd;

    assign w_raddr = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_old   = r_mem[w_raddr];

    always_ff @(posedge clk) begin
      if (w_mem_we) begin
        for (int b = 0; b < c_NUM_BYTES; b++) begin
          if (w_mem_strb[b]) begin
            r_mem[w_mem_addr][8*b +: 8] <= w_mem_data[8*b +: 8];
          end
        end
      end
    end

    // Write-first forwarding merges the incoming bytes over the stored word.
    always_comb begin
      w_fwd = w_old;
      if (WRITE_FIRST != 0 && we && w_raddr == waddr) begin
        for (int b = 0; b < c_NUM_BYTES; b++) begin
          if (wstrb[b]) begin
            w_fwd[8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_rdata <= '0;
      end else if (w_ready && re[k]) begin
        r_rdata <= w_fwd;
      end
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = r_rdata;
  end

endmodule
`default_nettype wire
